if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
- Fetch-to-decode pipeline buffer: a 2-entry FIFO holding {pc, instr} pairs between instruction fetch and decode, using a valid/ready handshake.
- Pre-decodes each head instruction into the 25-bit immediate field (instr[31:7]) and the 3-bit immediate-format select consumed by immediate_generator.
- Provides synchronous flush for taken branches/jumps and backpressure so decode stalls never drop instructions.

Parameters:
- XLEN, 32, width of pc and instruction words.
- DEPTH, 2, FIFO entries; legal values 2 or 4, power of two.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  buffer can accept; a transfer occurs when in_valid && in_ready.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- flush  input  1  discard all stored entries.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode accepts; a transfer occurs when out_valid && out_ready.
- out_pc  output  XLEN  head pc.
- out_pc_plus4  output  XLEN  head pc + 4, modulo 2^XLEN.
- out_instr  output  32  head instruction.
- out_imm_field  output  25  out_instr[31:7].
- out_imm_src  output  3  immediate format select.
- out_illegal  output  1  head opcode is not recognised.

Behaviour:
- Storage: circular buffer with rd_ptr, wr_ptr and count (0..DEPTH), all registered.
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0, all entries cleared.
  - in_ready = 1, out_valid = 0.
  - out_instr = 32'h00000013 (NOP), out_pc = 0, out_pc_plus4 = 4.
- in_ready = (count < DEPTH), derived from registered count only. No combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- Latency: an instruction enqueued at edge N is visible on out_* after edge N; out_valid rises in cycle N+1. There is no same-cycle bypass.
- Count update per edge:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue (legal when 0 < count < DEPTH).
- Full (count == DEPTH): in_ready = 0, so no enqueue occurs even if a dequeue happens the same cycle. in_ready rises the cycle after the dequeue.
- Empty: out_valid = 0. out_instr = NOP, out_pc / out_pc_plus4 hold the last dequeued values, and imm outputs are decoded from the NOP.
- Pointers wrap modulo DEPTH.
- Flush (synchronous): at the edge, count = 0 and rd_ptr = wr_ptr = 0.
  - Flush has priority over a same-cycle enqueue or dequeue; the incoming instruction is dropped.
  - out_valid = 0 the following cycle.
  - in_ready during the flush cycle is computed normally.
- out_imm_src decode from out_instr[6:0]:
  - 0000011, 0010011, 1100111 -> 3'b000 (I).
  - 0100011 -> 3'b001 (S).
  - 1100011 -> 3'b101 (B).
  - 0110111, 0010111 -> 3'b010 (U).
  - 1101111 -> 3'b110 (J).
  - 0110011, 1110011, 0001111 -> 3'b000, out_illegal = 0.
  - Any other opcode -> 3'b000, out_illegal = 1.
- out_illegal is qualified by out_valid; it is 0 when the buffer is empty.
- in_pc / in_instr are sampled only on an accepted transfer. Behaviour is undefined if in_valid is high with X data.

Optional Feature:
- Macro: IF_ID_STALL_COUNT_EN.
- When defined:
  - Adds output port stall_cycles (32 bits), reset to 0 asynchronously.
  - Increments each cycle where out_valid && !out_ready, saturating at 32'hFFFFFFFF.
  - Not cleared by flush.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: in_valid = 0 -> out_valid = 0, in_ready = 1, out_instr = 32'h00000013, out_imm_src = 3'b000, out_illegal = 0.
- Enqueue {pc = 0x100, instr = 0xFE010EE3 (BEQ)}, out_ready = 1 -> next cycle out_valid = 1, out_pc_plus4 = 0x104, out_imm_field = 0x1FC021D, out_imm_src = 3'b101; dequeued the following edge.
- out_ready = 0, push 3 instrs (SW 0x00112623, LUI 0x000122B7, JAL 0x0080006F) with DEPTH = 2 -> in_ready = 0 after 2 accepts. Third held upstream. Then out_ready = 1 drains SW (imm_src 001), LUI (010), JAL (110) in order.
- Full buffer, out_ready = 1 and in_valid = 1 in the same cycle -> dequeue only, count 2 -> 1, in_ready = 1 next cycle, no data loss or duplication.
- count = 1, flush = 1 with simultaneous enqueue of 0x00500093 -> next cycle out_valid = 0, count = 0. A later enqueue appears first with correct pc.
- Enqueue opcode 7'b1111111 (instr 0x0000007F) -> out_illegal = 1, out_imm_src = 3'b000. With IF_ID_STALL_COUNT_EN, holding out_ready = 0 for 5 cycles -> stall_cycles = 5.

Source files
------------

// File: rtl/if_id_buffer.sv
// Fetch-to-decode buffer: small FIFO of {pc, instr} with valid/ready handshake and immediate pre-decode.
// Optional macro IF_ID_STALL_COUNT_EN adds a saturating decode-stall cycle counter (stall_cycles).
module if_id_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [31:0]     out_instr,
    output logic [24:0]     out_imm_field,
    output logic [2:0]      out_imm_src,
    output logic            out_illegal
`ifdef IF_ID_STALL_COUNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [CNTW-1:0] count;
    logic [XLEN-1:0] last_pc;
    logic            enq;
    logic            deq;
    logic            illegal_op;

    // in_ready depends only on the registered count, so decode backpressure never reaches fetch combinationally
    assign in_ready  = (count < CNTW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (deq) begin
                last_pc <= pc_mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When empty, decode sees a NOP while the pc outputs keep the last instruction handed over
    assign out_pc        = out_valid ? pc_mem[rd_ptr] : last_pc;
    assign out_instr     = out_valid ? instr_mem[rd_ptr] : NOP;
    assign out_pc_plus4  = out_pc + XLEN'(4);
    assign out_imm_field = out_instr[31:7];

    always_comb begin
        out_imm_src = 3'b000;
        illegal_op  = 1'b0;
        case (out_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: out_imm_src = 3'b000;
            7'b0100011:                         out_imm_src = 3'b001;
            7'b1100011:                         out_imm_src = 3'b101;
            7'b0110111, 7'b0010111:             out_imm_src = 3'b010;
            7'b1101111:                         out_imm_src = 3'b110;
            7'b0110011, 7'b1110011, 7'b0001111: out_imm_src = 3'b000;
            default:                            illegal_op  = 1'b1;
        endcase
    end

    assign out_illegal = out_valid && illegal_op;

`ifdef IF_ID_STALL_COUNT_EN
    // Deliberately survives flush so it measures total decode stall time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed, table-driven bench for if_id_buffer (DEPTH = 2), plus hand-written flush, stall and reset sequences.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [24:0] out_imm_field;
    logic [2:0]  out_imm_src;
    logic        out_illegal;
`ifdef IF_ID_STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_base;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        erdy;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [2:0]  esrc;
        logic        eill;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    if_id_buffer #(.XLEN(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr),
        .out_imm_field(out_imm_field),
        .out_imm_src  (out_imm_src),
        .out_illegal  (out_illegal)
`ifdef IF_ID_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, take the edge, and settle 1 time unit past it
    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic erdy, input logic [31:0] epc,
                            input logic [31:0] einstr, input logic [2:0] esrc, input logic eill);
        logic [31:0] exp_field;
        exp_field = {7'b0, einstr[31:7]};
        checkOutput({tag, ".out_valid"},     32'(out_valid),     32'(ev));
        checkOutput({tag, ".in_ready"},      32'(in_ready),      32'(erdy));
        checkOutput({tag, ".out_pc"},        out_pc,             epc);
        checkOutput({tag, ".out_pc_plus4"},  out_pc_plus4,       epc + 32'd4);
        checkOutput({tag, ".out_instr"},     out_instr,          einstr);
        checkOutput({tag, ".out_imm_field"}, 32'(out_imm_field), exp_field);
        checkOutput({tag, ".out_imm_src"},   32'(out_imm_src),   32'(esrc));
        checkOutput({tag, ".out_illegal"},   32'(out_illegal),   32'(eill));
    endtask

    initial begin
        //           iv  pc            instr          ordy  fl    ev    erdy  epc           einstr         esrc    eill
        vecs[0]  = '{1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h00000013, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 32'h100,     32'hFE010EE3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h100,      32'hFE010EE3, 3'b101, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h100,      32'h00000013, 3'b000, 1'b0};
        vecs[3]  = '{1'b1, 32'h200,     32'h00112623,  1'b0, 1'b0, 1'b1, 1'b1, 32'h200,      32'h00112623, 3'b001, 1'b0};
        vecs[4]  = '{1'b1, 32'h204,     32'h000122B7,  1'b0, 1'b0, 1'b1, 1'b0, 32'h200,      32'h00112623, 3'b001, 1'b0};
        vecs[5]  = '{1'b1, 32'h208,     32'h0080006F,  1'b0, 1'b0, 1'b1, 1'b0, 32'h200,      32'h00112623, 3'b001, 1'b0};
        vecs[6]  = '{1'b1, 32'h208,     32'h0080006F,  1'b1, 1'b0, 1'b1, 1'b1, 32'h204,      32'h000122B7, 3'b010, 1'b0};
        vecs[7]  = '{1'b1, 32'h208,     32'h0080006F,  1'b0, 1'b0, 1'b1, 1'b0, 32'h204,      32'h000122B7, 3'b010, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h208,      32'h0080006F, 3'b110, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h208,      32'h00000013, 3'b000, 1'b0};
        vecs[10] = '{1'b1, 32'h300,     32'h00500093,  1'b0, 1'b0, 1'b1, 1'b1, 32'h300,      32'h00500093, 3'b000, 1'b0};
        vecs[11] = '{1'b1, 32'h304,     32'h00500093,  1'b0, 1'b1, 1'b0, 1'b1, 32'h208,      32'h00000013, 3'b000, 1'b0};
        vecs[12] = '{1'b1, 32'h400,     32'h0000007F,  1'b0, 1'b0, 1'b1, 1'b1, 32'h400,      32'h0000007F, 3'b000, 1'b1};
        vecs[13] = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h400,      32'h00000013, 3'b000, 1'b0};
        vecs[14] = '{1'b1, 32'h500,     32'h00000033,  1'b0, 1'b0, 1'b1, 1'b1, 32'h500,      32'h00000033, 3'b000, 1'b0};
        vecs[15] = '{1'b1, 32'h504,     32'h00000017,  1'b1, 1'b0, 1'b1, 1'b1, 32'h504,      32'h00000017, 3'b010, 1'b0};
        vecs[16] = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h504,      32'h00000013, 3'b000, 1'b0};
        vecs[17] = '{1'b1, 32'hFFFFFFFC,32'h00000073,  1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h00000073, 3'b000, 1'b0};
        vecs[18] = '{1'b0, 32'h0,       32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000013, 3'b000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b1, 32'h0, 32'h00000013, 3'b000, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
            checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].epc,
                     vecs[i].einstr, vecs[i].esrc, vecs[i].eill);
        end

        // Full buffer flushed while decode also accepts and fetch offers more: everything dropped
        applyStimulus(1'b1, 32'h600, 32'h00500093, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h604, 32'h00600113, 1'b0, 1'b0);
        checkAll("fill_full", 1'b1, 1'b0, 32'h600, 32'h00500093, 3'b000, 1'b0);
        applyStimulus(1'b1, 32'h608, 32'h00700193, 1'b1, 1'b1);
        checkAll("flush_full", 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000013, 3'b000, 1'b0);
        applyStimulus(1'b1, 32'h700, 32'h00C000EF, 1'b0, 1'b0);
        checkAll("post_flush", 1'b1, 1'b1, 32'h700, 32'h00C000EF, 3'b110, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkAll("post_flush_drain", 1'b0, 1'b1, 32'h700, 32'h00000013, 3'b000, 1'b0);

`ifdef IF_ID_STALL_COUNT_EN
        stall_base = stall_cycles;
        applyStimulus(1'b1, 32'h800, 32'h00000013, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("stall_delta", stall_cycles - stall_base, 32'd5);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // Asynchronous reset asserted between edges with an entry stored
        applyStimulus(1'b1, 32'h900, 32'h00000023, 1'b0, 1'b0);
        checkAll("pre_async_reset", 1'b1, 1'b1, 32'h900, 32'h00000023, 3'b001, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset", 1'b0, 1'b1, 32'h0, 32'h00000013, 3'b000, 1'b0);
`ifdef IF_ID_STALL_COUNT_EN
        checkOutput("async_reset.stall_cycles", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkAll("after_reset_idle", 1'b0, 1'b1, 32'h0, 32'h00000013, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
